icache_direct: RTL

- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller.
- Serves imemaddr/imemREN from the datapath with a combinational ihit/imemload on hit.
- On miss, runs a single-word fill through the iREN/iaddr/iwait/iload handshake.
- Provides hit/miss counters for performance debug.

---
 rtl/icache_direct.sv | 133 +++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, read-only, one-word-per-line instruction cache.
// Hits return data in the same cycle; a miss runs a single-word fill from memory.
module icache_direct #(
   parameter int SETS  = 16,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   // datapath fetch port
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   // memory controller port
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   // performance counters
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t state_reg, state_next;

   // word address of the outstanding miss; byte offset is always zero
   logic [29:0] miss_word_reg, miss_word_next;

   logic             valid_reg [SETS];
   logic [TAG_W-1:0] tag_reg   [SETS];
   logic [31:0]      data_reg  [SETS];

   logic [CNT_W-1:0] hit_count_reg, miss_count_reg;

   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             tag_match;
   logic             hit;
   logic             fill_done;

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = imemaddr[31:IDX_W+2];
   assign fill_idx = miss_word_reg[IDX_W-1:0];
   assign fill_tag = miss_word_reg[29:IDX_W];

   assign tag_match = valid_reg[req_idx] && (tag_reg[req_idx] == req_tag);
   assign hit       = (state_reg == IDLE) && imemREN && tag_match;
   assign fill_done = (state_reg == FILL) && !iwait;

   always_comb begin
      state_next     = state_reg;
      miss_word_next = miss_word_reg;
      ihit           = 1'b0;
      imemload       = 32'd0;
      iREN           = 1'b0;
      iaddr          = 32'd0;
      case (state_reg)
         IDLE: begin
            if (hit) begin
               ihit     = 1'b1;
               imemload = data_reg[req_idx];
            end else if (imemREN) begin
               miss_word_next = imemaddr[31:2];
               state_next     = FILL;
            end
         end
         FILL: begin
            // fill runs to completion regardless of redirects or halts upstream
            iREN  = 1'b1;
            iaddr = {miss_word_reg, 2'b00};
            if (!iwait) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg     <= IDLE;
         miss_word_reg <= 30'd0;
      end else begin
         state_reg     <= state_next;
         miss_word_reg <= miss_word_next;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SETS; i++) begin
            valid_reg[i] <= 1'b0;
            tag_reg[i]   <= '0;
            data_reg[i]  <= 32'd0;
         end
      end else if (fill_done) begin
         // unconditional overwrite: no write path, so evicted lines are never dirty
         valid_reg[fill_idx] <= 1'b1;
         tag_reg[fill_idx]   <= fill_tag;
         data_reg[fill_idx]  <= iload;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         if (hit) begin
            hit_count_reg <= hit_count_reg + CNT_W'(1);
         end
         if (fill_done) begin
            miss_count_reg <= miss_count_reg + CNT_W'(1);
         end
      end
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;

endmodule
